// File: rtl/dmem_port_ctrl_if.sv
// Data-memory bus between the memory-stage port controller and the data memory.
//   dmem_address  word-aligned byte address of the access
//   dmem_read     read request, held until dmem_resp
//   dmem_write    write request, held until dmem_resp
//   dmem_wmask    byte-lane enables
//   dmem_wdata    store data, replicated across the addressed lanes
//   dmem_rdata    read data returned by memory
//   dmem_resp     one-cycle pulse: memory has completed the access
// master: the controller; slave: the memory.
interface dmem_port_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned LANES = DATA_W / 8;

    logic [ADDR_W-1:0] dmem_address;
    logic              dmem_read;
    logic              dmem_write;
    logic [LANES-1:0]  dmem_wmask;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_resp;

    modport master (
        output dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_address, dmem_read, dmem_write, dmem_wmask, dmem_wdata,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/dmem_port_ctrl.sv
// Memory-stage data-port controller. Converts one pipeline load/store into a
// word-aligned dmem transaction with byte mask and lane-replicated store data,
// holds it until dmem_resp, stalls the pipeline meanwhile, and returns the raw
// read data plus the original byte address so writeback can align/sign-extend.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid           memory-stage op present
//   req_is_load/store   op type (store wins if both set)
//   req_funct3          RV32I funct3 (access size)
//   req_addr            byte address
//   req_wdata           store source (rs2)
//   stall               combinational: hold upstream pipeline registers
//   done                one-cycle completion pulse
//   misaligned          pulses with done when the op was dropped
//   rdata_out/addr_out  captured read data and original address, valid with done
//   dmem                data-memory bus (master side)
module dmem_port_ctrl #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_is_load,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              done,
    output logic              misaligned,
    output logic [DATA_W-1:0] rdata_out,
    output logic [ADDR_W-1:0] addr_out,
    dmem_port_ctrl_if.master  dmem
);
    localparam int unsigned LANES = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [LANES-1:0]  wmask_q, wmask_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_d, misaligned_d;
    logic [DATA_W-1:0] rdata_out_d;
    logic [ADDR_W-1:0] addr_out_d;

    logic              mem_op_c;
    logic              half_c, word_c, misaligned_c;
    logic [LANES-1:0]  st_mask_c;
    logic [DATA_W-1:0] st_wdata_c;

    assign mem_op_c = req_is_load | req_is_store;
    assign stall    = req_valid & mem_op_c & (state_q != DONE);

    // Access size and store lane placement. Unknown store funct3 acts as sw.
    always_comb begin
        half_c     = 1'b0;
        word_c     = 1'b0;
        st_mask_c  = LANES'(4'b1111);
        st_wdata_c = req_wdata;
        if (req_is_store) begin
            case (req_funct3)
                3'b000: begin
                    st_mask_c  = LANES'(4'b0001) << req_addr[1:0];
                    st_wdata_c = {4{req_wdata[7:0]}};
                end
                3'b001: begin
                    half_c     = 1'b1;
                    st_mask_c  = LANES'(4'b0011) << {req_addr[1], 1'b0};
                    st_wdata_c = {2{req_wdata[15:0]}};
                end
                default: word_c = 1'b1;
            endcase
        end else begin
            // lb/lbu share funct3[1:0]=00, lh/lhu share 01
            case (req_funct3[1:0])
                2'b01:   half_c = 1'b1;
                2'b10:   word_c = 1'b1;
                default: ;
            endcase
        end
        misaligned_c = (half_c & req_addr[0]) | (word_c & (|req_addr[1:0]));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        read_d       = read_q;
        write_d      = write_q;
        wmask_d      = wmask_q;
        wdata_d      = wdata_q;
        done_d       = 1'b0;
        misaligned_d = 1'b0;
        rdata_out_d  = rdata_out;
        addr_out_d   = addr_out;

        case (state_q)
            IDLE: begin
                if (req_valid && mem_op_c) begin
                    addr_out_d = req_addr;
                    if (misaligned_c) begin
                        // Dropped op: report completion without touching dmem.
                        state_d      = DONE;
                        done_d       = 1'b1;
                        misaligned_d = 1'b1;
                    end else begin
                        state_d   = BUSY;
                        address_d = {req_addr[ADDR_W-1:2], 2'b00};
                        read_d    = ~req_is_store;
                        write_d   = req_is_store;
                        wmask_d   = req_is_store ? st_mask_c : LANES'(4'b1111);
                        wdata_d   = req_is_store ? st_wdata_c : '0;
                    end
                end
            end
            BUSY: begin
                if (dmem.dmem_resp) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    rdata_out_d = dmem.dmem_rdata;
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            address_q  <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            wmask_q    <= '0;
            wdata_q    <= '0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            rdata_out  <= '0;
            addr_out   <= '0;
        end else begin
            state_q    <= state_d;
            address_q  <= address_d;
            read_q     <= read_d;
            write_q    <= write_d;
            wmask_q    <= wmask_d;
            wdata_q    <= wdata_d;
            done       <= done_d;
            misaligned <= misaligned_d;
            rdata_out  <= rdata_out_d;
            addr_out   <= addr_out_d;
        end
    end

    assign dmem.dmem_address = address_q;
    assign dmem.dmem_read    = read_q;
    assign dmem.dmem_write   = write_q;
    assign dmem.dmem_wmask   = wmask_q;
    assign dmem.dmem_wdata   = wdata_q;
endmodule
